// File: rtl/stdp_pair_monitor.sv
// stdp_pair_monitor: classifies pre/post spike pairings (LTP, LTD, coincident)
// by cycle distance and queues them in a first-word fall-through event FIFO.
// Build macro STDP_SPIKE_COUNT_EN adds saturating pre/post spike counters.
module stdp_pair_monitor #(
    parameter int unsigned DT_W   = 8,
    parameter int unsigned WINDOW = 100,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spike_pre,
    input  logic              spike_post,
    input  logic              ev_ready,
    input  logic              clr_stats,
    output logic              ev_valid,
    output logic [DT_W+1:0]   ev_data,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic [15:0]       cnt_pre,
    output logic [15:0]       cnt_post
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EV_W  = DT_W + 2;

    localparam logic [DT_W-1:0]  AGE_MAX  = {DT_W{1'b1}};
    localparam logic [DT_W-1:0]  WIN      = DT_W'(WINDOW);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [1:0]       CODE_LTP  = 2'b01;
    localparam logic [1:0]       CODE_LTD  = 2'b10;
    localparam logic [1:0]       CODE_COIN = 2'b11;

    logic              spike_pre_q;
    logic              spike_post_q;
    logic              pre_edge_c;
    logic              post_edge_c;
    logic              pre_seen;
    logic              post_seen;
    logic [DT_W-1:0]   pre_age;
    logic [DT_W-1:0]   post_age;

    logic              push_c;
    logic [EV_W-1:0]   push_data_c;

    logic [EV_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop_c;
    logic              full_c;
    logic              wr_c;
    logic              drop_c;
    logic [CNT_W-1:0]  count_next_c;
    logic [PTR_W-1:0]  rd_ptr_next_c;
    logic [EV_W-1:0]   head_next_c;

    assign pre_edge_c  = spike_pre  & ~spike_pre_q;
    assign post_edge_c = spike_post & ~spike_post_q;

    // Delay flops for rising-edge detection of the spike levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_pre_q  <= 1'b0;
            spike_post_q <= 1'b0;
        end else begin
            spike_pre_q  <= spike_pre;
            spike_post_q <= spike_post;
        end
    end

    // Cycles since the most recent pre/post spike, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_seen  <= 1'b0;
            post_seen <= 1'b0;
            pre_age   <= '0;
            post_age  <= '0;
        end else begin
            if (pre_edge_c) begin
                pre_seen <= 1'b1;
                pre_age  <= DT_W'(1);
            end else if (pre_seen && (pre_age != AGE_MAX)) begin
                pre_age <= pre_age + DT_W'(1);
            end
            if (post_edge_c) begin
                post_seen <= 1'b1;
                post_age  <= DT_W'(1);
            end else if (post_seen && (post_age != AGE_MAX)) begin
                post_age <= post_age + DT_W'(1);
            end
        end
    end

    // Nearest-neighbour pairing; coincidence takes priority over LTP/LTD.
    always_comb begin
        push_c      = 1'b0;
        push_data_c = '0;
        if (pre_edge_c && post_edge_c) begin
            push_c      = 1'b1;
            push_data_c = {CODE_COIN, {DT_W{1'b0}}};
        end else if (post_edge_c && pre_seen && (pre_age <= WIN)) begin
            push_c      = 1'b1;
            push_data_c = {CODE_LTP, pre_age};
        end else if (pre_edge_c && post_seen && (post_age <= WIN)) begin
            push_c      = 1'b1;
            push_data_c = {CODE_LTD, post_age};
        end
    end

    // FIFO control; a pop frees the slot so a push into a full FIFO is kept.
    always_comb begin
        pop_c         = ev_valid & ev_ready;
        full_c        = (count == FULL_CNT);
        wr_c          = push_c & (~full_c | pop_c);
        drop_c        = push_c & full_c & ~pop_c;
        count_next_c  = count + CNT_W'(wr_c) - CNT_W'(pop_c);
        rd_ptr_next_c = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        // Bypass the write when it lands on the slot that becomes the head.
        if (wr_c && (wr_ptr == rd_ptr_next_c)) begin
            head_next_c = push_data_c;
        end else begin
            head_next_c = mem[rd_ptr_next_c];
        end
    end

    // FIFO storage, pointers and registered head/valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ev_valid <= 1'b0;
            ev_data  <= '0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= push_data_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_next_c;
            count    <= count_next_c;
            ev_valid <= (count_next_c != '0);
            ev_data  <= head_next_c;
        end
    end

    // Sticky overflow flag and saturating drop counter; clear beats a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef STDP_SPIKE_COUNT_EN
    // Saturating spike counters, one count per rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_pre  <= '0;
            cnt_post <= '0;
        end else if (clr_stats) begin
            cnt_pre  <= '0;
            cnt_post <= '0;
        end else begin
            if (pre_edge_c && (cnt_pre != 16'hFFFF)) begin
                cnt_pre <= cnt_pre + 16'd1;
            end
            if (post_edge_c && (cnt_post != 16'hFFFF)) begin
                cnt_post <= cnt_post + 16'd1;
            end
        end
    end
`else
    assign cnt_pre  = '0;
    assign cnt_post = '0;
`endif

endmodule

// File: tb/tb_stdp_pair_monitor.sv
// Scoreboard bench for stdp_pair_monitor: expected events are queued as
// spikes are driven and compared in order as the FIFO is drained.
module tb_stdp_pair_monitor;

    localparam int unsigned DT_W = 8;
    localparam int unsigned EV_W = DT_W + 2;
`ifdef STDP_SPIKE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            spike_pre = 1'b0;
    logic            spike_post = 1'b0;
    logic            ev_ready = 1'b0;
    logic            clr_stats = 1'b0;
    logic            ev_valid;
    logic [EV_W-1:0] ev_data;
    logic            overflow;
    logic [7:0]      drop_cnt;
    logic [15:0]     cnt_pre;
    logic [15:0]     cnt_post;

    int vectors = 0;
    int miscompares = 0;
    int pop_count = 0;
    logic [EV_W-1:0] sb[$];

    stdp_pair_monitor #(.DT_W(DT_W), .WINDOW(100), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .spike_pre(spike_pre), .spike_post(spike_post),
        .ev_ready(ev_ready), .clr_stats(clr_stats), .ev_valid(ev_valid),
        .ev_data(ev_data), .overflow(overflow), .drop_cnt(drop_cnt),
        .cnt_pre(cnt_pre), .cnt_post(cnt_post)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted pop is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [EV_W-1:0] exp_ev;
        if (!rst && ev_valid && ev_ready) begin
            pop_count++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_event: got %h want none", ev_data);
            end else begin
                exp_ev = sb.pop_front();
                if (ev_data !== exp_ev) begin
                    miscompares++;
                    $display("FAIL sb_event: got %h want %h", ev_data, exp_ev);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        spike_pre = 1'b0;
        spike_post = 1'b0;
        ev_ready = 1'b0;
        clr_stats = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
    endtask

    // Isolated pre spike, then post spike k cycles later (k >= 1).
    task automatic ltp_pair(input int k, input bit store, input bit rdy_at_push);
        logic [EV_W-1:0] e;
        repeat (110) tick();
        spike_pre = 1'b1;
        tick();
        spike_pre = 1'b0;
        repeat (k - 1) tick();
        spike_post = 1'b1;
        e = {2'b01, DT_W'(k)};
        if (store) sb.push_back(e);
        ev_ready = rdy_at_push;
        tick();
        spike_post = 1'b0;
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen_valid;
        rst = 1'b1;
        spike_pre = 1'b1;
        spike_post = 1'b1;
        ev_ready = 1'b0;
        repeat (4) tick();
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ev_valid: got %b want 0", ev_valid); end
        vectors++; if (ev_data !== '0) begin miscompares++; $display("FAIL rst_ev_data: got %h want 000", ev_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        vectors++; if (cnt_pre !== 16'd0) begin miscompares++; $display("FAIL rst_cnt_pre: got %0d want 0", cnt_pre); end
        vectors++; if (cnt_post !== 16'd0) begin miscompares++; $display("FAIL rst_cnt_post: got %0d want 0", cnt_post); end
        spike_pre = 1'b0;
        spike_post = 1'b0;
        tick();
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (50) begin
            tick();
            if (ev_valid !== 1'b0) seen_valid = 1'b1;
        end
        vectors++; if (seen_valid) begin miscompares++; $display("FAIL idle_ev_valid: got 1 want 0"); end
    endtask

    task automatic test_ltp();
        apply_reset();
        repeat (9) tick();
        ltp_pair(20, 1'b1, 1'b0);
        vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL ltp_valid: got %b want 1", ev_valid); end
        vectors++; if (ev_data !== 10'h114) begin miscompares++; $display("FAIL ltp_data: got %h want 114", ev_data); end
        repeat (3) tick();
        vectors++; if (ev_data !== 10'h114) begin miscompares++; $display("FAIL ltp_hold: got %h want 114", ev_data); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL ltp_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_ltd_level();
        logic [15:0] exp_cnt;
        exp_cnt = CNT_EN ? 16'd1 : 16'd0;
        apply_reset();
        spike_post = 1'b1;
        repeat (5) tick();
        spike_pre = 1'b1;
        sb.push_back(10'h205);
        tick();
        vectors++; if (ev_data !== 10'h205) begin miscompares++; $display("FAIL ltd_data: got %h want 205", ev_data); end
        repeat (2) tick();
        spike_post = 1'b0;
        repeat (2) tick();
        spike_pre = 1'b0;
        repeat (5) tick();
        vectors++; if (cnt_pre !== exp_cnt) begin miscompares++; $display("FAIL ltd_cnt_pre: got %0d want %0d", cnt_pre, exp_cnt); end
        vectors++; if (cnt_post !== exp_cnt) begin miscompares++; $display("FAIL ltd_cnt_post: got %0d want %0d", cnt_post, exp_cnt); end
        pop_count = 0;
        ev_ready = 1'b1;
        repeat (4) tick();
        ev_ready = 1'b0;
        vectors++; if (pop_count !== 1) begin miscompares++; $display("FAIL ltd_event_count: got %0d want 1", pop_count); end
    endtask

    task automatic test_coincident();
        apply_reset();
        spike_pre = 1'b1;
        spike_post = 1'b1;
        sb.push_back(10'h300);
        repeat (4) tick();
        spike_pre = 1'b0;
        spike_post = 1'b0;
        repeat (3) tick();
        vectors++; if (ev_data !== 10'h300) begin miscompares++; $display("FAIL coin_data: got %h want 300", ev_data); end
        pop_count = 0;
        ev_ready = 1'b1;
        repeat (4) tick();
        ev_ready = 1'b0;
        vectors++; if (pop_count !== 1) begin miscompares++; $display("FAIL coin_event_count: got %0d want 1", pop_count); end
    endtask

    task automatic test_window();
        apply_reset();
        ltp_pair(100, 1'b1, 1'b0);
        vectors++; if (ev_data !== 10'h164) begin miscompares++; $display("FAIL win100_data: got %h want 164", ev_data); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        apply_reset();
        ltp_pair(101, 1'b0, 1'b0);
        repeat (5) tick();
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL win101_valid: got %b want 0", ev_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 1; k <= 6; k++) ltp_pair(k, k <= 4, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        vectors++; if (drop_cnt !== 8'd2) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        pop_count = 0;
        ev_ready = 1'b1;
        repeat (8) tick();
        ev_ready = 1'b0;
        vectors++; if (pop_count !== 4) begin miscompares++; $display("FAIL ovf_drained: got %0d want 4", pop_count); end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow: got %b want 0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_full_pop();
        apply_reset();
        for (int k = 1; k <= 4; k++) ltp_pair(k, 1'b1, 1'b0);
        ltp_pair(5, 1'b1, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL fullpop_drop_cnt: got %0d want 0", drop_cnt); end
        pop_count = 0;
        ev_ready = 1'b1;
        repeat (8) tick();
        ev_ready = 1'b0;
        vectors++; if (pop_count !== 4) begin miscompares++; $display("FAIL fullpop_remaining: got %0d want 4", pop_count); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL fullpop_sb_left: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ltp();
        test_ltd_level();
        test_coincident();
        test_window();
        test_overflow();
        test_full_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
